// File: rtl/spi_crc_slave_rx.sv
// SPI mode-0 responder with CRC-8 on both directions, all pins oversampled in clk_s.
// Define SPI_CRC_ERR_CNT_EN to add the saturating err_cnt output.
module spi_crc_slave_rx #(
    parameter int         DATA_WIDTH = 8,
    parameter logic [7:0] CRC_POLY   = 8'h07
) (
    input  logic                  clk_s,
    input  logic                  rst_n,
    input  logic                  sclk_s,
    input  logic                  ss,
    input  logic                  mosi,
    input  logic [DATA_WIDTH-1:0] data_in_slave,
    output logic                  miso,
    output logic [DATA_WIDTH-1:0] data_out_slave,
    output logic                  data_valid,
    output logic                  crc_err
`ifdef SPI_CRC_ERR_CNT_EN
    ,
    output logic [7:0]            err_cnt
`endif
);
    localparam int CW = $clog2(DATA_WIDTH + 9);

    typedef enum logic [2:0] {IDLE, SHIFT_DATA, SHIFT_CRC, CHECK, WAIT_SS} state_t;

    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
        crc8_step = {c[6:0], 1'b0} ^ ((c[7] ^ b) ? CRC_POLY : 8'h00);
    endfunction

    logic sclk_meta_q, sclk_sync_q, sclk_dly_q;
    logic ss_meta_q, ss_sync_q, ss_dly_q;
    logic mosi_meta_q, mosi_sync_q;

    state_t                state_q, state_d;
    logic                  miso_q, miso_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [7:0]            rx_crc_q, rx_crc_d;
    logic [7:0]            tx_crc_q, tx_crc_d;
    logic [7:0]            rx_crc_field_q, rx_crc_field_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  data_valid_q, data_valid_d;
    logic                  crc_err_q, crc_err_d;
    logic [7:0]            tx_crc_n;
`ifdef SPI_CRC_ERR_CNT_EN
    logic [7:0]            err_cnt_q, err_cnt_d;
`endif

    // Edges come from the synchronised level vs. its one-cycle-delayed copy,
    // so a rise and a fall can never be flagged together.
    logic sclk_rise, sclk_fall, ss_fall;
    assign sclk_rise = sclk_sync_q & ~sclk_dly_q;
    assign sclk_fall = ~sclk_sync_q & sclk_dly_q;
    assign ss_fall   = ~ss_sync_q & ss_dly_q;

    always_comb begin
        state_d        = state_q;
        miso_d         = miso_q;
        tx_shift_d     = tx_shift_q;
        rx_shift_d     = rx_shift_q;
        data_out_d     = data_out_q;
        rx_crc_d       = rx_crc_q;
        tx_crc_d       = tx_crc_q;
        rx_crc_field_d = rx_crc_field_q;
        bit_cnt_d      = bit_cnt_q;
        data_valid_d   = 1'b0;
        crc_err_d      = 1'b0;
        tx_crc_n       = crc8_step(tx_crc_q, tx_shift_q[DATA_WIDTH-1]);
        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (ss_fall) begin
                    tx_shift_d = data_in_slave;
                    rx_crc_d   = 8'h00;
                    tx_crc_d   = 8'h00;
                    bit_cnt_d  = '0;
                    miso_d     = data_in_slave[DATA_WIDTH-1];
                    state_d    = SHIFT_DATA;
                end
            end
            SHIFT_DATA: begin
                if (ss_sync_q) begin
                    miso_d  = 1'b0;
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    if (bit_cnt_q < CW'(DATA_WIDTH)) begin
                        rx_shift_d = DATA_WIDTH'({rx_shift_q, mosi_sync_q});
                        rx_crc_d   = crc8_step(rx_crc_q, mosi_sync_q);
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                    end
                end else if (sclk_fall) begin
                    tx_crc_d   = tx_crc_n;
                    tx_shift_d = tx_shift_q << 1;
                    if (bit_cnt_q == CW'(DATA_WIDTH)) begin
                        miso_d  = tx_crc_n[7];
                        state_d = SHIFT_CRC;
                    end else begin
                        miso_d = tx_shift_d[DATA_WIDTH-1];
                    end
                end
            end
            SHIFT_CRC: begin
                if (ss_sync_q) begin
                    miso_d  = 1'b0;
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    rx_crc_field_d = {rx_crc_field_q[6:0], mosi_sync_q};
                    bit_cnt_d      = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CW'(DATA_WIDTH + 7)) state_d = CHECK;
                end else if (sclk_fall) begin
                    tx_crc_d = tx_crc_q << 1;
                    miso_d   = tx_crc_q[6];
                end
            end
            CHECK: begin
                miso_d = 1'b0;
                if (rx_crc_field_q == rx_crc_q) begin
                    data_out_d   = rx_shift_q;
                    data_valid_d = 1'b1;
                end else begin
                    crc_err_d = 1'b1;
                end
                state_d = WAIT_SS;
            end
            WAIT_SS: begin
                miso_d = 1'b0;
                if (ss_sync_q) state_d = IDLE;
            end
            default: begin
                miso_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
`ifdef SPI_CRC_ERR_CNT_EN
        err_cnt_d = err_cnt_q;
        if (crc_err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
`endif
    end

    // Sync flops reset low so a frame only starts on a real high-to-low ss after reset.
    always_ff @(posedge clk_s or negedge rst_n) begin
        if (!rst_n) begin
            sclk_meta_q    <= 1'b0;
            sclk_sync_q    <= 1'b0;
            sclk_dly_q     <= 1'b0;
            ss_meta_q      <= 1'b0;
            ss_sync_q      <= 1'b0;
            ss_dly_q       <= 1'b0;
            mosi_meta_q    <= 1'b0;
            mosi_sync_q    <= 1'b0;
            state_q        <= IDLE;
            miso_q         <= 1'b0;
            tx_shift_q     <= '0;
            rx_shift_q     <= '0;
            data_out_q     <= '0;
            rx_crc_q       <= 8'h00;
            tx_crc_q       <= 8'h00;
            rx_crc_field_q <= 8'h00;
            bit_cnt_q      <= '0;
            data_valid_q   <= 1'b0;
            crc_err_q      <= 1'b0;
`ifdef SPI_CRC_ERR_CNT_EN
            err_cnt_q      <= 8'h00;
`endif
        end else begin
            sclk_meta_q    <= sclk_s;
            sclk_sync_q    <= sclk_meta_q;
            sclk_dly_q     <= sclk_sync_q;
            ss_meta_q      <= ss;
            ss_sync_q      <= ss_meta_q;
            ss_dly_q       <= ss_sync_q;
            mosi_meta_q    <= mosi;
            mosi_sync_q    <= mosi_meta_q;
            state_q        <= state_d;
            miso_q         <= miso_d;
            tx_shift_q     <= tx_shift_d;
            rx_shift_q     <= rx_shift_d;
            data_out_q     <= data_out_d;
            rx_crc_q       <= rx_crc_d;
            tx_crc_q       <= tx_crc_d;
            rx_crc_field_q <= rx_crc_field_d;
            bit_cnt_q      <= bit_cnt_d;
            data_valid_q   <= data_valid_d;
            crc_err_q      <= crc_err_d;
`ifdef SPI_CRC_ERR_CNT_EN
            err_cnt_q      <= err_cnt_d;
`endif
        end
    end

    assign miso           = miso_q;
    assign data_out_slave = data_out_q;
    assign data_valid     = data_valid_q;
    assign crc_err        = crc_err_q;
`ifdef SPI_CRC_ERR_CNT_EN
    assign err_cnt        = err_cnt_q;
`endif

endmodule

// File: tb/tb_spi_crc_slave_rx.sv
// Directed bench for spi_crc_slave_rx (DATA_WIDTH=8, CRC-8 poly 0x07).
module tb_spi_crc_slave_rx;
    logic       clk_s = 1'b0;
    logic       rst_n = 1'b1;
    logic       sclk_s = 1'b0;
    logic       ss = 1'b1;
    logic       mosi = 1'b0;
    logic [7:0] data_in_slave = 8'h00;
    logic       miso;
    logic [7:0] data_out_slave;
    logic       data_valid;
    logic       crc_err;
`ifdef SPI_CRC_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int passed = 0;
    int total = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int dv_cyc = 0;
    int dv_cnt = 0;
    int ce_cnt = 0;
    int bad_pulse = 0;
    int dv0, ce0;
    logic dv_prev = 1'b0;
    logic ce_prev = 1'b0;
    logic [15:0] mb;

    spi_crc_slave_rx #(.DATA_WIDTH(8), .CRC_POLY(8'h07)) dut (
        .clk_s          (clk_s),
        .rst_n          (rst_n),
        .sclk_s         (sclk_s),
        .ss             (ss),
        .mosi           (mosi),
        .data_in_slave  (data_in_slave),
        .miso           (miso),
        .data_out_slave (data_out_slave),
        .data_valid     (data_valid),
        .crc_err        (crc_err)
`ifdef SPI_CRC_ERR_CNT_EN
        ,
        .err_cnt        (err_cnt)
`endif
    );

    always #5 clk_s = ~clk_s;

    always @(posedge clk_s) cyc++;

    // Pulse bookkeeping, sampled on the inactive edge.
    always @(negedge clk_s) begin
        if (data_valid === 1'b1) begin
            dv_cnt++;
            dv_cyc = cyc;
        end
        if (crc_err === 1'b1) ce_cnt++;
        if ((data_valid === 1'b1 && dv_prev) || (crc_err === 1'b1 && ce_prev) ||
            (data_valid === 1'b1 && crc_err === 1'b1))
            bad_pulse++;
        dv_prev = (data_valid === 1'b1);
        ce_prev = (crc_err === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One ss-low window: nclk sclk periods, 16 frame bits then 1s; miso sampled before each rise.
    task automatic frame(input logic [7:0] d, input logic [7:0] c, input logic [7:0] din,
                         input int nclk, input int half, output logic [15:0] mbits);
        logic [15:0] fr;
        fr = {d, c};
        mbits = 16'h0000;
        data_in_slave = din;
        ss = 1'b0;
        repeat (6) @(negedge clk_s);
        for (int i = 0; i < nclk; i++) begin
            mosi = (i < 16) ? fr[15-i] : 1'b1;
            if (i == 4) data_in_slave = ~din;
            repeat (half) @(negedge clk_s);
            if (i < 16) mbits[15-i] = miso;
            sclk_s = 1'b1;
            rise_cyc = cyc;
            repeat (half) @(negedge clk_s);
            sclk_s = 1'b0;
        end
        repeat (half) @(negedge clk_s);
    endtask

    task automatic end_frame();
        ss = 1'b1;
        repeat (6) @(negedge clk_s);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk_s);
        chk("rst_miso", 32'(miso), 32'h0);
        chk("rst_dout", 32'(data_out_slave), 32'h0);
        chk("rst_dv", 32'(data_valid), 32'h0);
        chk("rst_ce", 32'(crc_err), 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk_s);

        // Good frame: A5 + CRC 72, slave returns 01 + CRC 07.
        dv0 = dv_cnt; ce0 = ce_cnt;
        frame(8'hA5, 8'h72, 8'h01, 16, 8, mb);
        chk("good_latency", dv_cyc - rise_cyc, 32'd4);
        end_frame();
        chk("good_dv", dv_cnt - dv0, 32'd1);
        chk("good_ce", ce_cnt - ce0, 32'd0);
        chk("good_dout", 32'(data_out_slave), 32'hA5);
        chk("good_miso", 32'(mb), 32'h0107);

        // Bad CRC: data held, slave word 5A has CRC 81.
        dv0 = dv_cnt; ce0 = ce_cnt;
        frame(8'hA5, 8'h73, 8'h5A, 16, 8, mb);
        end_frame();
        chk("bad_dv", dv_cnt - dv0, 32'd0);
        chk("bad_ce", ce_cnt - ce0, 32'd1);
        chk("bad_dout", 32'(data_out_slave), 32'hA5);
        chk("bad_miso", 32'(mb), 32'h5A81);
`ifdef SPI_CRC_ERR_CNT_EN
        chk("errcnt_one", 32'(err_cnt), 32'h1);
`endif

        // Abort after 5 sclk periods.
        dv0 = dv_cnt; ce0 = ce_cnt;
        frame(8'h3C, 8'h00, 8'h77, 5, 8, mb);
        end_frame();
        chk("abort_dv", dv_cnt - dv0, 32'd0);
        chk("abort_ce", ce_cnt - ce0, 32'd0);
        chk("abort_dout", 32'(data_out_slave), 32'hA5);

        // Recovery frame 01 / 07.
        dv0 = dv_cnt; ce0 = ce_cnt;
        frame(8'h01, 8'h07, 8'hA5, 16, 8, mb);
        end_frame();
        chk("after_abort_dv", dv_cnt - dv0, 32'd1);
        chk("after_abort_dout", 32'(data_out_slave), 32'h01);
        chk("after_abort_miso", 32'(mb), 32'hA572);

        // Zero frame.
        dv0 = dv_cnt; ce0 = ce_cnt;
        frame(8'h00, 8'h00, 8'h00, 16, 8, mb);
        end_frame();
        chk("zero_dv", dv_cnt - dv0, 32'd1);
        chk("zero_ce", ce_cnt - ce0, 32'd0);
        chk("zero_dout", 32'(data_out_slave), 32'h00);
        chk("zero_miso", 32'(mb), 32'h0000);

        // 18 sclk pulses in one window: the two extras are ignored.
        dv0 = dv_cnt; ce0 = ce_cnt;
        frame(8'hA5, 8'h72, 8'h01, 18, 8, mb);
        end_frame();
        chk("extra_dv", dv_cnt - dv0, 32'd1);
        chk("extra_ce", ce_cnt - ce0, 32'd0);
        chk("extra_dout", 32'(data_out_slave), 32'hA5);

        // Asynchronous reset in the middle of a frame with miso driving a 1.
        data_in_slave = 8'hFF;
        ss = 1'b0;
        repeat (6) @(negedge clk_s);
        for (int i = 0; i < 3; i++) begin
            mosi = 1'b1;
            repeat (8) @(negedge clk_s);
            sclk_s = 1'b1;
            repeat (8) @(negedge clk_s);
            sclk_s = 1'b0;
        end
        repeat (4) @(negedge clk_s);
        chk("pre_rst_miso", 32'(miso), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst_miso", 32'(miso), 32'h0);
        chk("midrst_dout", 32'(data_out_slave), 32'h0);
        chk("midrst_dv", 32'(data_valid), 32'h0);
        chk("midrst_ce", 32'(crc_err), 32'h0);
        ss = 1'b1;
        repeat (3) @(negedge clk_s);
        rst_n = 1'b1;
        repeat (4) @(negedge clk_s);

        // Post-reset frame confirms the FSM came back to IDLE.
        dv0 = dv_cnt; ce0 = ce_cnt;
        frame(8'h5A, 8'h81, 8'h00, 16, 8, mb);
        end_frame();
        chk("post_rst_dv", dv_cnt - dv0, 32'd1);
        chk("post_rst_dout", 32'(data_out_slave), 32'h5A);

`ifdef SPI_CRC_ERR_CNT_EN
        chk("errcnt_after_rst", 32'(err_cnt), 32'h0);
        for (int k = 0; k < 300; k++) begin
            frame(8'hA5, 8'h73, 8'h00, 16, 3, mb);
            end_frame();
        end
        chk("errcnt_sat", 32'(err_cnt), 32'hFF);
`endif

        chk("pulse_shape", bad_pulse, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/spi_crc_slave_rx.md
Name: spi_crc_slave_rx

Overview:
SPI responder (mode 0, MSB first) for the CRC-protected link.
- Receives a frame of DATA_WIDTH data bits plus an 8-bit CRC on mosi, and checks the CRC.
- Simultaneously returns its own data word followed by its own CRC on miso.
- All SPI pins are oversampled in the single clk_s domain. The block sits at the slave end of the link, facing a CRC-capable SPI master.

Parameters:
DATA_WIDTH, 8, payload bits per frame (>=1)
CRC_POLY, 8'h07, CRC-8 polynomial (x^8+x^2+x+1), init 8'h00, no reflection, no final XOR

Ports:
clk_s  input  1  system clock; must be >=4x sclk_s frequency
rst_n  input  1  asynchronous reset, active-low
sclk_s  input  1  SPI clock from master, asynchronous to clk_s
ss  input  1  slave select, active-low
mosi  input  1  serial data from master
data_in_slave  input  DATA_WIDTH  word to return; sampled at frame start
miso  output  1  serial data to master
data_out_slave  output  DATA_WIDTH  last payload received with good CRC
data_valid  output  1  1-cycle pulse: data_out_slave updated
crc_err  output  1  1-cycle pulse: received CRC mismatch

Behaviour:
- Synchronisation and edge detection:
  - sclk_s, ss and mosi each pass through a 2-flop synchroniser.
  - Edges are detected on the synchronised signals, one register stage behind.
- Reset (async, rst_n=0): state IDLE; miso=0; data_out_slave=0; data_valid=0; crc_err=0; internal CRC and shift registers cleared.
- IDLE:
  - miso=0.
  - On a synchronised ss falling edge: load tx_shift<=data_in_slave, clear rx_crc and tx_crc, bit_cnt<=0, go to SHIFT_DATA.
  - miso drives tx_shift MSB from the next cycle.
  - The master must allow >=4 clk_s cycles between ss falling and the first sclk_s rise.
- SHIFT_DATA:
  - On a detected sclk rise: rx_shift<={rx_shift,mosi_sync}; rx_crc is updated serially with mosi_sync; bit_cnt++.
  - On a detected sclk fall: tx_crc is updated serially with the bit just sent; tx_shift shifts left; miso<=new MSB.
  - After the DATA_WIDTH-th fall, go to SHIFT_CRC with miso<=tx_crc[7].
- SHIFT_CRC:
  - On a rise: rx_crc_field<={rx_crc_field,mosi_sync}.
  - On a fall: miso shifts out the next tx_crc bit, MSB first.
  - After 8 rises (total DATA_WIDTH+8), go to CHECK.
- CHECK (exactly 1 cycle):
  - If rx_crc_field==rx_crc: data_out_slave<=rx_shift and data_valid=1 next cycle.
  - Otherwise crc_err=1 next cycle and data_out_slave holds.
  - Then go to WAIT_SS.
- WAIT_SS:
  - miso=0; any further sclk edges are ignored.
  - On synchronised ss high, go to IDLE.
- Latency: data_valid/crc_err assert 4 clk_s cycles after the final sclk_s rise at the pin (2 sync + 1 edge stage + CHECK).
- ss deasserted mid-frame (SHIFT_DATA/SHIFT_CRC): abort to IDLE, no pulse, data_out_slave unchanged.
- ss low again while in WAIT_SS without passing high: no new frame starts.
- A rise and a fall are never detected in the same cycle. If the sync pipeline shows both, the rise takes priority.
- data_valid and crc_err are mutually exclusive and never asserted for more than 1 cycle.
- Changes to data_in_slave during a frame have no effect.

Optional Feature:
SPI_CRC_ERR_CNT_EN
- Defined: adds output err_cnt (8 bits).
  - Reset value 0.
  - Increments on each crc_err pulse, saturates at 8'hFF.
  - Cleared only by rst_n.
- Undefined: err_cnt port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: rst_n low mid-frame -> miso=0, data_out_slave=0, data_valid=0, crc_err=0 immediately (asynchronous); state IDLE.
- Good frame, DATA_WIDTH=8:
  - Stimulus: master sends 0xA5 then CRC 0x72; data_in_slave=0x01.
  - Required: data_valid pulse, data_out_slave=0xA5, crc_err=0; miso returns 0x01 then 0x07.
- Bad CRC: master sends 0xA5 then 0x73 -> crc_err pulse 1 cycle, data_out_slave keeps its previous value, no data_valid.
- Zero frame: master sends 0x00/0x00; data_in_slave=0x00 -> data_valid, data_out_slave=0x00; miso all zeros for 16 bits.
- Abort: ss raised after 5 sclk cycles -> no pulse, data_out_slave unchanged; the next full frame 0x01/0x07 is received correctly.
- Back-to-back frames and extra clocks:
  - Stimulus: 18 sclk pulses within one ss-low window.
  - Required: pulse exactly once; the extra 2 pulses are ignored.
  - With SPI_CRC_ERR_CNT_EN defined, 300 bad frames -> err_cnt=8'hFF.
